// File: rtl/riscy_pkg.sv
// Shared front-end types and constants: datapath widths, PC step and the fetch packet
// handed from fetch to decode.
package riscy_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned PC_STEP     = 4;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instruction;
    } fetch_packet_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO between instruction memory and decode. The head entry is itself a
// register, so decode never sees a combinational path from the memory data.
module fetch_skid_buffer
    import riscy_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_packet_t push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_packet_t head,
    output logic          head_valid,
    output logic [1:0]    count_c
);

    fetch_packet_t tail;
    logic          tail_valid;

    fetch_packet_t head_d;
    fetch_packet_t tail_d;
    logic          head_valid_d;
    logic          tail_valid_d;
    logic          pop_eff;

    assign pop_eff = pop & head_valid;
    assign count_c = 2'(head_valid) + 2'(tail_valid);

    // Next-entry selection; the caller's credit scheme guarantees no push while full.
    always_comb begin
        head_d       = head;
        tail_d       = tail;
        head_valid_d = head_valid;
        tail_valid_d = tail_valid;
        if (flush) begin
            head_valid_d = 1'b0;
            tail_valid_d = 1'b0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (!head_valid) begin
                        head_d       = push_data;
                        head_valid_d = 1'b1;
                    end else begin
                        tail_d       = push_data;
                        tail_valid_d = 1'b1;
                    end
                end
                2'b01: begin
                    head_d       = tail;
                    head_valid_d = tail_valid;
                    tail_valid_d = 1'b0;
                end
                2'b11: begin
                    if (tail_valid) begin
                        head_d = tail;
                        tail_d = push_data;
                    end else begin
                        head_d = push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
        end else begin
            head       <= head_d;
            tail       <= tail_d;
            head_valid <= head_valid_d;
            tail_valid <= tail_valid_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch requester: owns the PC, issues one word per cycle under a two-slot credit limit,
// and redirects/squashes on taken branches.
module instruction_fetch_unit
    import riscy_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  instructionAddress,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   branchTaken,
    input  logic [ADDR_WIDTH-1:0]  branchTarget,
    output logic                   fetchValid,
    input  logic                   fetchReady,
    output logic [INSTR_WIDTH-1:0] fetchInstruction,
    output logic [ADDR_WIDTH-1:0]  fetchPC
);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;

    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_d;

    logic                  pop_c;
    logic                  push_c;
    logic                  issue_c;
    logic [1:0]            count_c;
    logic [2:0]            occupancy_c;
    fetch_packet_t         push_data;
    fetch_packet_t         head;
    logic                  head_valid;

    assign instructionAddress = pc;
    assign fetchValid         = head_valid;
    assign fetchPC            = head.pc;
    assign fetchInstruction   = head.instruction;

    assign pop_c  = head_valid & fetchReady;
    assign push_c = inflight & ~branchTaken;
    assign push_data = '{pc: inflight_pc, instruction: instruction};

    // Buffered plus outstanding entries may never exceed the two FIFO slots.
    assign occupancy_c = 3'(count_c) + 3'(inflight);
    assign issue_c     = ~branchTaken & (occupancy_c < (3'd2 + 3'(pop_c)));

    always_comb begin
        pc_d          = pc;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc;
        if (branchTaken) begin
            pc_d = align_word(branchTarget);
        end else if (issue_c) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc;
            pc_d          = pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            pc          <= pc_d;
            inflight    <= inflight_d;
            inflight_pc <= inflight_pc_d;
        end
    end

    fetch_skid_buffer u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .push_data  (push_data),
        .pop        (pop_c),
        .flush      (branchTaken),
        .head       (head),
        .head_valid (head_valid),
        .count_c    (count_c)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit, checked against a program-order
// delivery model (next expected PC) and a registered memory model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] WPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] instructionAddress;
    logic [31:0] instruction;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchInstruction;
    logic [31:0] fetchPC;

    logic        w_reset;
    logic [31:0] w_instructionAddress;
    logic [31:0] w_instruction;
    logic        w_branchTaken;
    logic [31:0] w_branchTarget;
    logic        w_fetchValid;
    logic        w_fetchReady;
    logic [31:0] w_fetchInstruction;
    logic [31:0] w_fetchPC;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk                (clk),
        .reset              (reset),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .branchTaken        (branchTaken),
        .branchTarget       (branchTarget),
        .fetchValid         (fetchValid),
        .fetchReady         (fetchReady),
        .fetchInstruction   (fetchInstruction),
        .fetchPC            (fetchPC)
    );

    instruction_fetch_unit #(.RESET_PC(WPC)) dut_wrap (
        .clk                (clk),
        .reset              (w_reset),
        .instructionAddress (w_instructionAddress),
        .instruction        (w_instruction),
        .branchTaken        (w_branchTaken),
        .branchTarget       (w_branchTarget),
        .fetchValid         (w_fetchValid),
        .fetchReady         (w_fetchReady),
        .fetchInstruction   (w_fetchInstruction),
        .fetchPC            (w_fetchPC)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    // Registered-read instruction memories with one cycle of latency.
    always @(posedge clk) instruction   <= mem_word(instructionAddress);
    always @(posedge clk) w_instruction <= mem_word(w_instructionAddress);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: verify any transfer against the program-order model, then advance.
    task automatic tick();
        logic        hold;
        logic [31:0] held_pc;
        hold    = fetchValid && !fetchReady && !branchTaken && !reset;
        held_pc = fetchPC;
        if (!reset && fetchValid && fetchReady) begin
            check("deliver_pc", fetchPC, exp_pc);
            check("deliver_instr", fetchInstruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (reset) exp_pc = RPC;
        else if (branchTaken) exp_pc = branchTarget & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_valid", 32'(fetchValid), 32'd1);
            check("hold_pc", fetchPC, held_pc);
        end
        check("addr_align", 32'(instructionAddress[1:0]), 32'd0);
    endtask

    task automatic cold_start();
        fetchReady  = 1'b1;
        branchTaken = 1'b0;
        reset       = 1'b0;
        exp_pc      = RPC;
        check("cs_addr0", instructionAddress, RPC);
        check("cs_valid0", 32'(fetchValid), 32'd0);
        tick();
        check("cs_addr1", instructionAddress, RPC + 32'd4);
        check("cs_valid1", 32'(fetchValid), 32'd0);
        tick();
        check("cs_addr2", instructionAddress, RPC + 32'd8);
        check("cs_valid2", 32'(fetchValid), 32'd1);
        check("cs_pc2", fetchPC, RPC);
        tick();
        check("cs_pc3", fetchPC, RPC + 32'd4);
        tick();
        check("cs_pc4", fetchPC, RPC + 32'd8);
    endtask

    initial begin
        logic [31:0] frozen;
        reset          = 1'b1;
        fetchReady     = 1'b0;
        branchTaken    = 1'b0;
        branchTarget   = 32'h0;
        w_reset        = 1'b1;
        w_fetchReady   = 1'b1;
        w_branchTaken  = 1'b0;
        w_branchTarget = 32'h0;
        exp_pc         = RPC;
        repeat (3) @(posedge clk);
        #1;

        // Address wrap on the second instance.
        check("w_rst_addr", w_instructionAddress, WPC);
        check("w_rst_valid", 32'(w_fetchValid), 32'd0);
        check("w_rst_pc", w_fetchPC, 32'h0);
        w_reset = 1'b0;
        check("w_addr0", w_instructionAddress, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        check("w_addr1", w_instructionAddress, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("w_addr2", w_instructionAddress, 32'h0000_0000);
        check("w_valid2", 32'(w_fetchValid), 32'd1);
        check("w_pc2", w_fetchPC, 32'hFFFF_FFF8);
        check("w_instr2", w_fetchInstruction, mem_word(32'hFFFF_FFF8));
        @(posedge clk); #1;
        check("w_pc3", w_fetchPC, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("w_pc4", w_fetchPC, 32'h0000_0000);
        check("w_instr4", w_fetchInstruction, mem_word(32'h0000_0000));
        w_reset = 1'b1;

        // Reset values and cold start.
        check("rst_addr", instructionAddress, RPC);
        check("rst_valid", 32'(fetchValid), 32'd0);
        check("rst_pc", fetchPC, 32'h0);
        check("rst_instr", fetchInstruction, 32'h0);
        cold_start();

        // Steady state: one instruction per cycle.
        repeat (4) begin
            tick();
            check("steady_valid", 32'(fetchValid), 32'd1);
        end

        // Backpressure for five cycles, then resume with no bubble.
        fetchReady = 1'b0;
        tick();
        tick();
        frozen = instructionAddress;
        repeat (3) begin
            tick();
            check("bp_freeze", instructionAddress, frozen);
            check("bp_valid", 32'(fetchValid), 32'd1);
        end
        fetchReady = 1'b1;
        repeat (4) begin
            tick();
            check("bp_no_bubble", 32'(fetchValid), 32'd1);
        end

        // Redirect with two entries buffered and no pop.
        fetchReady = 1'b0;
        tick();
        tick();
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_2003;
        tick();
        branchTaken = 1'b0;
        check("br_valid1", 32'(fetchValid), 32'd0);
        check("br_addr1", instructionAddress, 32'h0000_2000);
        fetchReady = 1'b1;
        tick();
        check("br_valid2", 32'(fetchValid), 32'd0);
        tick();
        check("br_valid3", 32'(fetchValid), 32'd1);
        check("br_pc3", fetchPC, 32'h0000_2000);
        repeat (3) tick();

        // Branch coinciding with a pop: head delivered once, rest flushed.
        fetchReady = 1'b0;
        tick();
        tick();
        fetchReady   = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_3000;
        tick();
        branchTaken = 1'b0;
        check("bp_col_valid", 32'(fetchValid), 32'd0);
        check("bp_col_addr", instructionAddress, 32'h0000_3000);
        tick();
        tick();
        check("bp_col_pc", fetchPC, 32'h0000_3000);
        repeat (2) tick();

        // Reset mid-stream with the buffer full, then a fresh cold start.
        fetchReady = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mr_valid", 32'(fetchValid), 32'd0);
        check("mr_pc", fetchPC, 32'h0);
        check("mr_instr", fetchInstruction, 32'h0);
        check("mr_addr", instructionAddress, RPC);
        cold_start();

        // Randomized traffic against the delivery model.
        repeat (600) begin
            fetchReady   = ($urandom_range(0, 3) != 0);
            branchTaken  = ($urandom_range(0, 19) == 0);
            branchTarget = $urandom;
            reset        = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset       = 1'b0;
        branchTaken = 1'b0;
        fetchReady  = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
